mmio_timer: RTL and testbench

//   Memory-mapped down-counting timer that responds on the data-RAM bus driven by openmips (ram_ce/we/addr/sel/data).

---
 rtl/mmio_timer_if.sv | 22 ++
 rtl/mmio_timer.sv | 147 ++++++++++++++
 tb/tb_mmio_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// Data-RAM side bus shared by openmips and the memory-mapped timer.
// The CPU side drives the access strobe, address, byte enables and write data;
// the timer answers with read data and a window-hit flag for the read mux.
interface mmio_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, hit_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, hit_o
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer on the openmips data-RAM bus.
// Registers: CTRL(0x00) LOAD(0x04) COUNT(0x08) STAT(0x0C), plus PRESC(0x10)
// when the build macro TIMER_PRESCALE_EN is defined. Without the macro the
// counter ticks on every enabled cycle and 0x10 behaves as an empty slot.
// Outside its 32-byte window the block stays silent (hit_o=0, data_o=0) so
// data_ram serves the access.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  mmio_timer_if.slave bus,
  output logic        timer_int_o
);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_LOAD  = 3'd1;
  localparam logic [2:0] A_COUNT = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_PRESC = 3'd4;

  logic             en, auto_rl, ie, expd;
  logic [CNT_W-1:0] load, count;

  logic             hit, wr, rd;
  logic [2:0]       idx;
  logic             wr_ctrl, wr_load, wr_count, wr_stat;
  logic             tick, cnt_zero, expire;
  logic [31:0]      load_w, count_w, presc_rd, rdata;
  logic [1:0]       unused_addr_lsb;

  // Byte-lane merge: lanes with sel set take the new data, others keep old.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  assign unused_addr_lsb = bus.addr[1:0];

  assign hit      = bus.ce & (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign wr       = hit & bus.we;
  assign rd       = hit & ~bus.we;
  assign idx      = bus.addr[4:2];
  assign wr_ctrl  = wr & (idx == A_CTRL);
  assign wr_load  = wr & (idx == A_LOAD);
  assign wr_count = wr & (idx == A_COUNT);
  assign wr_stat  = wr & (idx == A_STAT);

  assign load_w   = byte_merge(32'(load),  bus.data_i, bus.sel);
  assign count_w  = byte_merge(32'(count), bus.data_i, bus.sel);

  assign cnt_zero = (count == '0);
  assign expire   = tick & cnt_zero;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc, pcnt;
  logic        wr_presc;
  logic [31:0] presc_w;

  assign wr_presc = wr & (idx == A_PRESC);
  assign presc_w  = byte_merge({16'h0, presc}, bus.data_i, bus.sel);
  assign tick     = en & (pcnt == presc);
  assign presc_rd = {16'h0, presc};

  // Prescaler: divide enabled cycles by PRESC+1; restart on any reconfiguration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_presc)
        presc <= presc_w[15:0];
      if (wr_presc || wr_ctrl || !en || pcnt == presc)
        pcnt <= '0;
      else
        pcnt <= pcnt + 16'd1;
    end
  end
`else
  assign tick     = en;
  assign presc_rd = 32'h0;
`endif

  // Control and status: CTRL write beats one-shot EN clear; expiry beats W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      expd    <= 1'b0;
    end else begin
      if (wr_ctrl && bus.sel[0]) begin
        en      <= bus.data_i[0];
        auto_rl <= bus.data_i[1];
        ie      <= bus.data_i[2];
      end else if (expire && !auto_rl) begin
        en      <= 1'b0;
      end
      if (expire)
        expd <= 1'b1;
      else if (wr_stat && bus.sel[0] && bus.data_i[0])
        expd <= 1'b0;
    end
  end

  // Reload register and down-counter; a bus write to COUNT overrides the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load  <= '0;
      count <= '0;
    end else begin
      if (wr_load)
        load <= load_w[CNT_W-1:0];
      if (wr_count)
        count <= count_w[CNT_W-1:0];
      else if (tick) begin
        if (!cnt_zero)
          count <= count - CNT_W'(1);
        else if (auto_rl)
          count <= load;
      end
    end
  end

  // Register read mux; unmapped offsets read zero.
  always_comb begin
    rdata = 32'h0;
    case (idx)
      A_CTRL:  rdata = {29'h0, ie, auto_rl, en};
      A_LOAD:  rdata = 32'(load);
      A_COUNT: rdata = 32'(count);
      A_STAT:  rdata = {31'h0, expd};
      A_PRESC: rdata = presc_rd;
      default: rdata = 32'h0;
    endcase
  end

  assign bus.data_o  = rd ? rdata : 32'h0;
  assign bus.hit_o   = hit;
  assign timer_int_o = expd & ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, one-shot, auto-reload, byte lanes,
// write/tick collision and the tick rate with or without TIMER_PRESCALE_EN.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] O_CTRL  = 32'h00;
  localparam logic [31:0] O_LOAD  = 32'h04;
  localparam logic [31:0] O_COUNT = 32'h08;
  localparam logic [31:0] O_STAT  = 32'h0C;
  localparam logic [31:0] O_PRESC = 32'h10;

  logic clk = 1'b0;
  logic rst;
  logic timer_int_o;
  int   n_vec = 0;
  int   n_err = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = BASE + off; bus.data_i = d; bus.sel = be;
    step();
    bus.ce = 1'b0; bus.we = 1'b0; bus.sel = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = BASE + off;
    #1;
    check(tag, bus.data_o, exp);
    bus.ce = 1'b0;
  endtask

  task automatic int_chk(input string tag, input logic exp);
    check(tag, {31'h0, timer_int_o}, {31'h0, exp});
  endtask

  initial begin
    rst = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    int_chk("rst_int", 1'b0);
    rst = 1'b1;
    step();
    rd_chk("rst_ctrl", O_CTRL, 32'h0);
    rd_chk("rst_count", O_COUNT, 32'h0);
    rd_chk("rst_stat", O_STAT, 32'h0);

    // One-shot from COUNT=3 with IE set
    bus_wr(O_COUNT, 32'd3, 4'hF);
    bus_wr(O_CTRL, 32'h5, 4'hF);
    step(); rd_chk("os_cnt2", O_COUNT, 32'd2);
    step(); rd_chk("os_cnt1", O_COUNT, 32'd1);
    step(); rd_chk("os_cnt0", O_COUNT, 32'd0);
    rd_chk("os_noexp", O_STAT, 32'h0);
    step();
    rd_chk("os_exp", O_STAT, 32'h1);
    int_chk("os_int", 1'b1);
    rd_chk("os_en_off", O_CTRL, 32'h4);
    step(); rd_chk("os_hold0", O_COUNT, 32'd0);
    bus_wr(O_STAT, 32'h1, 4'h1);
    int_chk("os_w1c_int", 1'b0);
    rd_chk("os_w1c_stat", O_STAT, 32'h0);

    // Auto-reload, LOAD=4: expiry every 5 ticks
    bus_wr(O_LOAD, 32'd4, 4'hF);
    bus_wr(O_COUNT, 32'd0, 4'hF);
    bus_wr(O_CTRL, 32'h7, 4'hF);
    step();
    rd_chk("ar_exp1", O_STAT, 32'h1);
    rd_chk("ar_reload", O_COUNT, 32'd4);
    int_chk("ar_int1", 1'b1);
    bus_wr(O_STAT, 32'h1, 4'hF);
    int_chk("ar_clr_int", 1'b0);
    rd_chk("ar_cnt3", O_COUNT, 32'd3);
    repeat (3) step();
    rd_chk("ar_cnt0", O_COUNT, 32'd0);
    rd_chk("ar_noexp", O_STAT, 32'h0);
    step();
    rd_chk("ar_exp2", O_STAT, 32'h1);
    rd_chk("ar_reload2", O_COUNT, 32'd4);
    repeat (4) step();
    rd_chk("ar_pre_col", O_COUNT, 32'd0);
    bus_wr(O_STAT, 32'h1, 4'hF);
    rd_chk("ar_col_exp", O_STAT, 32'h1);
    int_chk("ar_col_int", 1'b1);

    // Byte lanes, sel=0, address decode
    bus_wr(O_CTRL, 32'h0, 4'hF);
    bus_wr(O_STAT, 32'h1, 4'hF);
    bus_wr(O_LOAD, 32'hAABBCCDD, 4'hF);
    bus_wr(O_LOAD, 32'h11223344, 4'b0101);
    rd_chk("bl_load", O_LOAD, 32'hAA22CC44);
    bus_wr(O_LOAD, 32'h0, 4'h0);
    rd_chk("bl_sel0", O_LOAD, 32'hAA22CC44);
    rd_chk("bl_lsb_ign", O_LOAD + 32'h3, 32'hAA22CC44);
    rd_chk("bl_unmapped", 32'h18, 32'h0);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = BASE + O_LOAD;
    #1;
    check("bl_hit", {31'h0, bus.hit_o}, 32'h1);
    bus.addr = BASE + 32'h24;
    #1;
    check("bl_out_hit", {31'h0, bus.hit_o}, 32'h0);
    check("bl_out_data", bus.data_o, 32'h0);
    bus.ce = 1'b0; bus.addr = BASE + O_LOAD;
    #1;
    check("bl_ce0_hit", {31'h0, bus.hit_o}, 32'h0);

    // COUNT write on a ticking cycle wins over the decrement
    bus_wr(O_COUNT, 32'h20, 4'hF);
    bus_wr(O_CTRL, 32'h1, 4'hF);
    bus_wr(O_COUNT, 32'h10, 4'hF);
    rd_chk("col_cnt", O_COUNT, 32'h10);
    step();
    rd_chk("col_dec", O_COUNT, 32'h0F);
    bus_wr(O_CTRL, 32'h0, 4'hF);

    // Tick rate
    bus_wr(O_COUNT, 32'd1, 4'hF);
    bus_wr(O_STAT, 32'h1, 4'hF);
`ifdef TIMER_PRESCALE_EN
    bus_wr(O_PRESC, 32'd2, 4'hF);
    rd_chk("ps_presc", O_PRESC, 32'd2);
    bus_wr(O_CTRL, 32'h1, 4'hF);
    repeat (5) step();
    rd_chk("ps_cnt0", O_COUNT, 32'd0);
    rd_chk("ps_noexp5", O_STAT, 32'h0);
    step();
    rd_chk("ps_exp6", O_STAT, 32'h1);
`else
    bus_wr(O_PRESC, 32'hFFFF, 4'hF);
    rd_chk("np_presc0", O_PRESC, 32'h0);
    bus_wr(O_CTRL, 32'h1, 4'hF);
    step();
    rd_chk("np_cnt0", O_COUNT, 32'd0);
    rd_chk("np_noexp1", O_STAT, 32'h0);
    step();
    rd_chk("np_exp2", O_STAT, 32'h1);
`endif
    rd_chk("tr_en_off", O_CTRL, 32'h0);

    // Reset mid-count with EXP set
    bus_wr(O_LOAD, 32'd3, 4'hF);
    bus_wr(O_CTRL, 32'h7, 4'hF);
    int_chk("mr_int_pre", 1'b1);
    step();
    #2;
    rst = 1'b0;
    #1;
    int_chk("mr_int_async", 1'b0);
    rd_chk("mr_cnt_in_rst", O_COUNT, 32'h0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rd_chk("mr_ctrl", O_CTRL, 32'h0);
    rd_chk("mr_load", O_LOAD, 32'h0);
    rd_chk("mr_count", O_COUNT, 32'h0);
    rd_chk("mr_stat", O_STAT, 32'h0);
    repeat (3) step();
    int_chk("mr_int_post", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
